hazard_unit_mc: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage RISC-V pipeline, successor to the single-cycle-memory hazard logic. It adds a data-memory wait state machine for `MEM_LAT`-cycle memory, and a back-end stall (`stallE`, `stallM`) with W-stage bubbles. It also provides saturating performance counters. It sits beside the datapath, reads register indices and control fields from the D/E/M/W stages, and drives stall, flush and forward-select lines.

---
 rtl/hazard_unit_mc.sv | 174 +++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard, forwarding and data-memory wait control for the
// five-stage pipeline, with saturating performance counters.
//   in : clk, rstN, D/E/M/W register indices, result selects, PCSrcE,
//        regWriteM/W, memReqM
//   out: stallF/D/E/M, flushD/E/W, forwardAE/BE, memBusy,
//        loadUseCnt, memStallCnt, flushCnt
module hazard_unit_mc #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [REG_AW-1:0] RS1D,
    input  logic [REG_AW-1:0] RS2D,
    input  logic [REG_AW-1:0] RS1E,
    input  logic [REG_AW-1:0] RS2E,
    input  logic [REG_AW-1:0] RDE,
    input  logic [1:0]        resultSrcE,
    input  logic [1:0]        PCSrcE,
    input  logic [REG_AW-1:0] RDM,
    input  logic              regWriteM,
    input  logic [1:0]        resultSrcM,
    input  logic              memReqM,
    input  logic [REG_AW-1:0] RDW,
    input  logic              regWriteW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              memBusy,
    output logic [CNT_W-1:0]  loadUseCnt,
    output logic [CNT_W-1:0]  memStallCnt,
    output logic [CNT_W-1:0]  flushCnt
);

    localparam int            CW    = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] LAST  = CW'(MEM_LAT - 1);
    localparam bit            MULTI = (MEM_LAT > 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          memStall;
    logic          redir;
    logic          useHaz;
    logic          stallAct;
    logic          redirAct;
    logic          hazAct;

    // M-stage loads and PC+4 are not forwardable from M; they fall to W.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic              wM,
        input logic [REG_AW-1:0] rdM,
        input logic [1:0]        srcM,
        input logic              wW,
        input logic [REG_AW-1:0] rdW
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wW && rdW != '0 && rdW == rs)
            sel = 2'b01;
        if (wM && rdM != '0 && rdM == rs) begin
            if (srcM == 2'b00)
                sel = 2'b10;
            else if (srcM == 2'b11)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rstN) begin
            forwardAE = fwdSel(RS1E, regWriteM, RDM,
                               resultSrcM, regWriteW, RDW);
            forwardBE = fwdSel(RS2E, regWriteM, RDM,
                               resultSrcM, regWriteW, RDW);
        end
    end

    // In WAIT, cnt runs 1..MEM_LAT-1; the last count releases M.
    always_comb begin
        memStall = 1'b0;
        if (rstN) begin
            if (state == WAIT)
                memStall = (cnt != LAST);
            else
                memStall = MULTI && memReqM;
        end
    end

    assign redir  = rstN && (PCSrcE != 2'b00);
    assign useHaz = rstN
                 && (resultSrcE == 2'b01 || resultSrcE == 2'b10)
                 && (RDE != '0)
                 && (RDE == RS1D || RDE == RS2D);

    // Mutually exclusive after priority masking.
    assign stallAct = memStall;
    assign redirAct = redir && !memStall;
    assign hazAct   = useHaz && !memStall && !redir;

    always_comb begin
        {stallF, stallD, stallE, stallM} = 4'b0000;
        {flushD, flushE, flushW}         = 3'b000;
        unique case (1'b1)
            stallAct: begin
                {stallF, stallD, stallE, stallM} = 4'b1111;
                flushW = 1'b1;
            end
            redirAct: begin
                flushD = 1'b1;
                flushE = 1'b1;
            end
            hazAct: begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
            default: ;
        endcase
    end

    assign memBusy = rstN && (state == WAIT);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MULTI && memReqM) begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            loadUseCnt  <= '0;
            memStallCnt <= '0;
            flushCnt    <= '0;
        end else begin
            if (hazAct && loadUseCnt != '1)
                loadUseCnt <= loadUseCnt + CNT_W'(1);
            if (stallAct && memStallCnt != '1)
                memStallCnt <= memStallCnt + CNT_W'(1);
            if (redirAct && flushCnt != '1)
                flushCnt <= flushCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed and randomized checks of hazard_unit_mc
// on three configurations (MEM_LAT/CNT_W = 3/8, 3/2, 1/32).
module tb_hazard_unit_mc;

    localparam int NI = 3;
    localparam int AW = 5;

    // Packed view of one instance: {fa, fb, sF, sD, sE, sM, fD, fE, fW, busy}
    localparam logic [11:0] MEM_STALL = 12'h0F2;
    localparam logic [11:0] REDIR     = 12'h00C;
    localparam logic [11:0] HAZ       = 12'h0C4;
    localparam logic [11:0] BUSY      = 12'h001;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    logic [AW-1:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
    logic [1:0]    resultSrcE, PCSrcE, resultSrcM;
    logic          regWriteM, memReqM, regWriteW;

    logic [11:0] act [NI];
    logic [63:0] luO [NI];
    logic [63:0] msO [NI];
    logic [63:0] flO [NI];

    int     lat [NI] = '{3, 3, 1};
    int     cw  [NI] = '{8, 2, 32};
    int     pos [NI];
    longint luC [NI];
    longint msC [NI];
    longint flC [NI];

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gDut
        localparam int LAT = (g == 2) ? 1 : 3;
        localparam int CWG = (g == 0) ? 8 : ((g == 1) ? 2 : 32);
        logic sF, sD, sE, sM, fD, fE, fW, busy;
        logic [1:0] fa, fb;
        logic [CWG-1:0] lu, ms, fl;
        hazard_unit_mc #(
            .REG_AW(AW), .MEM_LAT(LAT), .CNT_W(CWG)
        ) dut (
            .clk(clk), .rstN(rstN),
            .RS1D(RS1D), .RS2D(RS2D),
            .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
            .resultSrcE(resultSrcE), .PCSrcE(PCSrcE),
            .RDM(RDM), .regWriteM(regWriteM),
            .resultSrcM(resultSrcM), .memReqM(memReqM),
            .RDW(RDW), .regWriteW(regWriteW),
            .stallF(sF), .stallD(sD), .stallE(sE), .stallM(sM),
            .flushD(fD), .flushE(fE), .flushW(fW),
            .forwardAE(fa), .forwardBE(fb), .memBusy(busy),
            .loadUseCnt(lu), .memStallCnt(ms), .flushCnt(fl)
        );
        assign act[g] = {fa, fb, sF, sD, sE, sM, fD, fE, fW, busy};
        assign luO[g] = 64'(lu);
        assign msO[g] = 64'(ms);
        assign flO[g] = 64'(fl);
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] fwdModel(input logic [AW-1:0] rs);
        if (regWriteM && RDM != 0 && RDM == rs) begin
            if (resultSrcM == 2'b00) return 2'b10;
            if (resultSrcM == 2'b11) return 2'b11;
        end
        if (regWriteW && RDW != 0 && RDW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Position of the current cycle within an access (1..lat), 0 = none.
    function automatic int curPos(input int i);
        if (pos[i] > 0) return pos[i];
        return (memReqM && lat[i] > 1) ? 1 : 0;
    endfunction

    function automatic bit mStall(input int i);
        int cp = curPos(i);
        return cp > 0 && cp < lat[i];
    endfunction

    function automatic bit redirM();
        return rstN && PCSrcE != 2'b00;
    endfunction

    function automatic bit hazM();
        return rstN && (resultSrcE == 2'b01 || resultSrcE == 2'b10)
            && RDE != 0 && (RDE == RS1D || RDE == RS2D);
    endfunction

    function automatic logic [11:0] expOut(input int i);
        logic [11:0] e = '0;
        if (!rstN) return e;
        e[11:10] = fwdModel(RS1E);
        e[9:8]   = fwdModel(RS2E);
        e[0]     = pos[i] > 0;
        if (mStall(i))     e |= MEM_STALL;
        else if (redirM()) e |= REDIR;
        else if (hazM())   e |= HAZ;
        return e;
    endfunction

    function automatic longint satv(input longint v, input int i);
        longint mx = (longint'(1) << cw[i]) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic modelCommit();
        for (int i = 0; i < NI; i++) begin
            int cp;
            if (!rstN) continue;
            cp = curPos(i);
            if (mStall(i))     msC[i]++;
            else if (redirM()) flC[i]++;
            else if (hazM())   luC[i]++;
            if (cp == 0 || cp >= lat[i]) pos[i] = 0;
            else pos[i] = cp + 1;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            pos[i] = 0;
            luC[i] = 0;
            msC[i] = 0;
            flC[i] = 0;
        end
    endtask

    task automatic tick();
        modelCommit();
        @(posedge clk);
        #1;
    endtask

    task automatic zeroIn();
        RS1D = '0; RS2D = '0; RS1E = '0; RS2E = '0;
        RDE = '0; RDM = '0; RDW = '0;
        resultSrcE = '0; PCSrcE = '0; resultSrcM = '0;
        regWriteM = 1'b0; memReqM = 1'b0; regWriteW = 1'b0;
    endtask

    task automatic applyReset();
        zeroIn();
        rstN = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        memReqM = 1; PCSrcE = 2'b01; resultSrcE = 2'b01;
        RDE = 3; RS1D = 3; regWriteM = 1; RDM = 4; RS1E = 4;
        resultSrcM = 2'b00; regWriteW = 1; RDW = 6; RS2E = 6;
        RS2D = 0;
        #1;
        rstN = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== 12'h000) begin
                nErr++;
                $display("FAIL reset_outputs inst%0d: got %h want 000",
                         i, act[i]);
            end
            nVec++;
            if ((luO[i] | msO[i] | flO[i]) !== 64'd0) begin
                nErr++;
                $display("FAIL reset_counters inst%0d: got %0d/%0d/%0d want 0",
                         i, luO[i], msO[i], flO[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== 12'h000) begin
                nErr++;
                $display("FAIL reset_held inst%0d: got %h want 000",
                         i, act[i]);
            end
        end
        zeroIn();
        #2;
        rstN = 1'b1;
        #1;
        tick();
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== 12'h000) begin
                nErr++;
                $display("FAIL reset_release inst%0d: got %h want 000",
                         i, act[i]);
            end
            nVec++;
            if ((luO[i] | msO[i] | flO[i]) !== 64'd0) begin
                nErr++;
                $display("FAIL reset_release_cnt inst%0d: got %0d/%0d/%0d want 0",
                         i, luO[i], msO[i], flO[i]);
            end
        end
    endtask

    task automatic test_forwarding();
        // wM, srcM, RDM, RDW, RS2E, expA, expB
        int rows [6][7] = '{
            '{1, 0, 5, 5, 5, 2, 2},
            '{1, 3, 5, 5, 5, 3, 3},
            '{0, 3, 5, 5, 9, 1, 0},
            '{1, 1, 5, 5, 5, 1, 1},
            '{1, 2, 5, 0, 5, 0, 0},
            '{0, 0, 0, 0, 5, 0, 0}
        };
        applyReset();
        RS1E = 5;
        regWriteW = 1;
        for (int r = 0; r < 6; r++) begin
            regWriteM  = 1'(rows[r][0]);
            resultSrcM = 2'(rows[r][1]);
            RDM        = AW'(rows[r][2]);
            RDW        = AW'(rows[r][3]);
            RS2E       = AW'(rows[r][4]);
            #1;
            for (int i = 0; i < NI; i++) begin
                nVec++;
                if (act[i][11:10] !== 2'(rows[r][5])) begin
                    nErr++;
                    $display("FAIL fwdA row%0d inst%0d: got %b want %b",
                             r, i, act[i][11:10], 2'(rows[r][5]));
                end
                nVec++;
                if (act[i][9:8] !== 2'(rows[r][6])) begin
                    nErr++;
                    $display("FAIL fwdB row%0d inst%0d: got %b want %b",
                             r, i, act[i][9:8], 2'(rows[r][6]));
                end
            end
        end
        zeroIn();
    endtask

    task automatic test_load_use();
        applyReset();
        resultSrcE = 2'b01; RDE = 7; RS2D = 7;
        #1;
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== HAZ) begin
                nErr++;
                $display("FAIL load_use inst%0d: got %h want %h",
                         i, act[i], HAZ);
            end
            nVec++;
            if (luO[i] !== 64'd0) begin
                nErr++;
                $display("FAIL load_use_cnt0 inst%0d: got %0d want 0",
                         i, luO[i]);
            end
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (luO[i] !== 64'd1) begin
                nErr++;
                $display("FAIL load_use_cnt1 inst%0d: got %0d want 1",
                         i, luO[i]);
            end
        end
        resultSrcE = 2'b10; RDE = 0; RS1D = 0; RS2D = 0;
        #1;
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== 12'h000) begin
                nErr++;
                $display("FAIL load_use_x0 inst%0d: got %h want 000",
                         i, act[i]);
            end
        end
        zeroIn();
    endtask

    task automatic test_redirect_vs_hazard();
        resultSrcE = 2'b01; RDE = 7; RS2D = 7; PCSrcE = 2'b01;
        #1;
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== REDIR) begin
                nErr++;
                $display("FAIL redir_vs_haz inst%0d: got %h want %h",
                         i, act[i], REDIR);
            end
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (flO[i] !== 64'd1 || luO[i] !== 64'd1) begin
                nErr++;
                $display("FAIL redir_vs_haz_cnt inst%0d: got fl=%0d lu=%0d want 1/1",
                         i, flO[i], luO[i]);
            end
        end
        zeroIn();
    endtask

    task automatic test_mem_wait();
        applyReset();
        memReqM = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [11:0] e = '0;
                if (i < 2) begin
                    if (k % 3 != 0) e |= MEM_STALL;
                    if (k % 3 != 1) e |= BUSY;
                end
                nVec++;
                if (act[i] !== e) begin
                    nErr++;
                    $display("FAIL mem_wait k%0d inst%0d: got %h want %h",
                             k, i, act[i], e);
                end
            end
            tick();
            if (k % 3 == 0) begin
                for (int i = 0; i < NI; i++) begin
                    longint e = (i < 2) ? 2 * k / 3 : 0;
                    if (i == 1 && e > 3) e = 3;
                    nVec++;
                    if (msO[i] !== 64'(e)) begin
                        nErr++;
                        $display("FAIL mem_stall_cnt k%0d inst%0d: got %0d want %0d",
                                 k, i, msO[i], e);
                    end
                end
            end
        end
        memReqM = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== 12'h000) begin
                nErr++;
                $display("FAIL mem_wait_idle inst%0d: got %h want 000",
                         i, act[i]);
            end
        end
    endtask

    task automatic test_redirect_during_wait();
        applyReset();
        memReqM = 1'b1;
        PCSrcE  = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [11:0] e;
                if (i == 2)     e = REDIR;
                else if (k < 3) e = MEM_STALL | ((k > 1) ? BUSY : 12'h0);
                else            e = REDIR | BUSY;
                nVec++;
                if (act[i] !== e) begin
                    nErr++;
                    $display("FAIL redir_wait k%0d inst%0d: got %h want %h",
                             k, i, act[i], e);
                end
            end
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            longint e = (i == 2) ? 3 : 1;
            nVec++;
            if (flO[i] !== 64'(e)) begin
                nErr++;
                $display("FAIL redir_wait_cnt inst%0d: got %0d want %0d",
                         i, flO[i], e);
            end
        end
        zeroIn();
    endtask

    task automatic test_reset_mid_wait();
        applyReset();
        memReqM = 1'b1;
        #1;
        tick();
        nVec++;
        if (act[0][0] !== 1'b1) begin
            nErr++;
            $display("FAIL mid_wait_busy: got %b want 1", act[0][0]);
        end
        rstN = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== 12'h000 || msO[i] !== 64'd0) begin
                nErr++;
                $display("FAIL mid_wait_reset inst%0d: got %h cnt=%0d want 000 cnt=0",
                         i, act[i], msO[i]);
            end
        end
        memReqM = 1'b0;
        #2;
        rstN = 1'b1;
        #1;
        tick();
        for (int i = 0; i < NI; i++) begin
            nVec++;
            if (act[i] !== 12'h000 || (luO[i] | msO[i] | flO[i]) !== 64'd0) begin
                nErr++;
                $display("FAIL mid_wait_release inst%0d: got %h cnt=%0d/%0d/%0d want 000 0/0/0",
                         i, act[i], luO[i], msO[i], flO[i]);
            end
        end
    endtask

    task automatic test_random();
        applyReset();
        for (int n = 0; n < 600; n++) begin
            RS1D = AW'($urandom_range(0, 3));
            RS2D = AW'($urandom_range(0, 3));
            RS1E = AW'($urandom_range(0, 3));
            RS2E = AW'($urandom_range(0, 3));
            RDE  = AW'($urandom_range(0, 3));
            RDM  = AW'($urandom_range(0, 3));
            RDW  = AW'($urandom_range(0, 3));
            resultSrcE = 2'($urandom);
            resultSrcM = 2'($urandom);
            PCSrcE = ($urandom_range(0, 5) == 0)
                   ? 2'($urandom_range(1, 3)) : 2'b00;
            regWriteM = 1'($urandom);
            regWriteW = 1'($urandom);
            memReqM = ($urandom_range(0, 2) == 0);
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [11:0] e = expOut(i);
                nVec++;
                if (act[i] !== e) begin
                    nErr++;
                    $display("FAIL rand_out n%0d inst%0d: got %h want %h",
                             n, i, act[i], e);
                end
                nVec++;
                if (luO[i] !== 64'(satv(luC[i], i))) begin
                    nErr++;
                    $display("FAIL rand_lu n%0d inst%0d: got %0d want %0d",
                             n, i, luO[i], satv(luC[i], i));
                end
                nVec++;
                if (msO[i] !== 64'(satv(msC[i], i))) begin
                    nErr++;
                    $display("FAIL rand_ms n%0d inst%0d: got %0d want %0d",
                             n, i, msO[i], satv(msC[i], i));
                end
                nVec++;
                if (flO[i] !== 64'(satv(flC[i], i))) begin
                    nErr++;
                    $display("FAIL rand_fl n%0d inst%0d: got %0d want %0d",
                             n, i, flO[i], satv(flC[i], i));
                end
            end
            tick();
        end
        zeroIn();
    endtask

    initial begin
        modelReset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_redirect_vs_hazard();
        test_mem_wait();
        test_redirect_during_wait();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
